reg_scoreboard: RTL and testbench

- Parametrised register-hazard scoreboard for the decode stage of the 16-bit pipelined core.
- Generalises the fixed 8-register, 3-bit register-invalid tracker.
- Tracks every in-flight register write as one slot per pipeline stage between EX and WB.
- Per read port it reports the forwarding source and load-use stall, and supports per-stage selective flush on jump-prediction misses.

---
 rtl/reg_scoreboard.sv | 117 +++++++++++
 tb/tb_reg_scoreboard.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the decode stage: tracks in-flight register
// writes per pipeline stage and derives forwarding selects and load-use stalls.
module reg_scoreboard #(
    parameter int AW         = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int ZERO_REG   = 0,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adv,
    input  logic                issue,
    input  logic [AW-1:0]       issue_adr,
    input  logic                issue_load,
    input  logic [DEPTH-1:0]    flush,
    input  logic                ra_en,
    input  logic [AW-1:0]       ra_adr,
    input  logic                rb_en,
    input  logic [AW-1:0]       rb_adr,
    output logic [FW-1:0]       ra_fwd,
    output logic [FW-1:0]       rb_fwd,
    output logic                stall,
    output logic                issue_accepted,
    output logic [2**AW-1:0]    pending
);

    localparam int NREG = 2**AW;

    logic [DEPTH-1:0]         v_q, v_d;
    logic [DEPTH-1:0][AW-1:0] adr_q, adr_d;
    logic [DEPTH-1:0]         ld_q, ld_d;
    logic [FW:0]              look_a_s, look_b_s;

    // Returns {stall, forward code} for one read port; the lowest matching slot
    // (youngest writer) wins, and a match in the last slot reads the register file.
    function automatic logic [FW:0] lookup(
        input logic                     en,
        input logic [AW-1:0]            a,
        input logic [DEPTH-1:0]         v,
        input logic [DEPTH-1:0][AW-1:0] adrs,
        input logic [DEPTH-1:0]         lds
    );
        logic          hit_s;
        logic          st_s;
        logic [FW-1:0] code_s;
        hit_s  = 1'b0;
        st_s   = 1'b0;
        code_s = {FW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit_s && en && v[k] && (adrs[k] == a) &&
                !((ZERO_REG != 0) && (a == {AW{1'b0}}))) begin
                hit_s = 1'b1;
                if (k < DEPTH - 1) begin
                    code_s = FW'(k + 1);
                end else begin
                    code_s = {FW{1'b0}};
                end
                st_s = lds[k] && (code_s != {FW{1'b0}}) && (int'(code_s) < LOAD_READY);
            end else begin
                hit_s = hit_s;
            end
        end
        return {st_s, code_s};
    endfunction

    // Port lookups, stall and issue acceptance
    always_comb begin
        look_a_s       = lookup(ra_en, ra_adr, v_q, adr_q, ld_q);
        look_b_s       = lookup(rb_en, rb_adr, v_q, adr_q, ld_q);
        ra_fwd         = look_a_s[FW-1:0];
        rb_fwd         = look_b_s[FW-1:0];
        stall          = look_a_s[FW] | look_b_s[FW];
        issue_accepted = issue & adv & ~stall;
    end

    // Next slot state: flush clears first, then the pipe shifts on adv
    always_comb begin
        v_d   = v_q & ~flush;
        adr_d = adr_q;
        ld_d  = ld_q;
        if (adv) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                v_d[k]   = v_q[k-1] & ~flush[k-1];
                adr_d[k] = adr_q[k-1];
                ld_d[k]  = ld_q[k-1];
            end
            v_d[0]   = issue_accepted && !((ZERO_REG != 0) && (issue_adr == {AW{1'b0}}));
            adr_d[0] = issue_adr;
            ld_d[0]  = issue_load;
        end else begin
            v_d = v_q & ~flush;
        end
    end

    // Per-register pending map
    always_comb begin
        pending = {NREG{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            pending = pending | (NREG'(v_q[k]) << adr_q[k]);
        end
    end

    // Slot state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= {DEPTH{1'b0}};
            adr_q <= {(DEPTH*AW){1'b0}};
            ld_q  <= {DEPTH{1'b0}};
        end else begin
            v_q   <= v_d;
            adr_q <= adr_d;
            ld_q  <= ld_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a model of in-flight writes (by age)
// predicts outputs per cycle; a monitor pops expectations and compares.
module tb_reg_scoreboard;

    localparam int AW         = 3;
    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 2;
    localparam int ZERO_REG   = 1;
    localparam int FW         = $clog2(DEPTH + 1);
    localparam int NREG       = 2**AW;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             adv = 1'b0, issue = 1'b0, issue_load = 1'b0;
    logic [AW-1:0]    issue_adr = '0, ra_adr = '0, rb_adr = '0;
    logic [DEPTH-1:0] flush = '0;
    logic             ra_en = 1'b0, rb_en = 1'b0;
    logic [FW-1:0]    ra_fwd, rb_fwd;
    logic             stall, issue_accepted;
    logic [NREG-1:0]  pending;

    always #5 clk = ~clk;

    reg_scoreboard #(.AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
                     .ZERO_REG(ZERO_REG), .FW(FW)) dut (
        .clk(clk), .reset(reset), .adv(adv), .issue(issue), .issue_adr(issue_adr),
        .issue_load(issue_load), .flush(flush), .ra_en(ra_en), .ra_adr(ra_adr),
        .rb_en(rb_en), .rb_adr(rb_adr), .ra_fwd(ra_fwd), .rb_fwd(rb_fwd),
        .stall(stall), .issue_accepted(issue_accepted), .pending(pending)
    );

    // Reference model: each accepted write remembers how many advances had
    // happened when it entered; its stage is its age in advances.
    typedef struct {
        logic [AW-1:0] adr;
        bit            ld;
        int            stamp;
        bit            alive;
    } wr_t;

    typedef struct {
        logic [FW-1:0]   fa;
        logic [FW-1:0]   fb;
        logic            st;
        logic            acc;
        logic [NREG-1:0] pend;
    } exp_t;

    wr_t  inflight[$];
    exp_t exp_q[$];
    int   adv_cnt = 0;
    bit   cur_acc = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int stage_of(input wr_t w);
        return adv_cnt - w.stamp - 1;
    endfunction

    function automatic void model_lookup(input logic en, input logic [AW-1:0] a,
                                         output int code, output bit st);
        int best;
        bit bld;
        best = DEPTH;
        bld  = 1'b0;
        if (en && !(ZERO_REG != 0 && a == 0)) begin
            foreach (inflight[i]) begin
                int s;
                s = stage_of(inflight[i]);
                if (inflight[i].alive && s < DEPTH && inflight[i].adr == a && s < best) begin
                    best = s;
                    bld  = inflight[i].ld;
                end
            end
        end
        code = (best < DEPTH - 1) ? best + 1 : 0;
        st   = bld && code != 0 && code < LOAD_READY;
    endfunction

    function automatic logic [NREG-1:0] model_pending();
        logic [NREG-1:0] p;
        p = '0;
        foreach (inflight[i])
            if (inflight[i].alive && stage_of(inflight[i]) < DEPTH) p[inflight[i].adr] = 1'b1;
        return p;
    endfunction

    // Applies one clock edge to the model using the inputs held during the cycle.
    task automatic model_edge();
        wr_t keep[$];
        if (reset == 1'b0) return;
        foreach (inflight[i]) begin
            int s;
            s = stage_of(inflight[i]);
            if (s >= 0 && s < DEPTH && flush[s]) inflight[i].alive = 1'b0;
        end
        if (adv) begin
            if (cur_acc && !(ZERO_REG != 0 && issue_adr == 0))
                inflight.push_back('{adr: issue_adr, ld: issue_load, stamp: adv_cnt, alive: 1'b1});
            adv_cnt++;
        end
        foreach (inflight[i])
            if (inflight[i].alive && stage_of(inflight[i]) < DEPTH) keep.push_back(inflight[i]);
        inflight = keep;
    endtask

    task automatic drive(input bit rst_v, input bit a_v, input bit i_v, input logic [AW-1:0] ia,
                         input bit il, input logic [DEPTH-1:0] fl, input bit rae,
                         input logic [AW-1:0] raa, input bit rbe, input logic [AW-1:0] rba);
        exp_t e;
        int   ca, cb;
        bit   sa, sb;
        @(posedge clk);
        model_edge();
        #1;
        reset = rst_v;
        if (!rst_v) inflight.delete();
        adv = a_v; issue = i_v; issue_adr = ia; issue_load = il; flush = fl;
        ra_en = rae; ra_adr = raa; rb_en = rbe; rb_adr = rba;
        model_lookup(rae, raa, ca, sa);
        model_lookup(rbe, rba, cb, sb);
        e.fa   = FW'(ca);
        e.fb   = FW'(cb);
        e.st   = sa | sb;
        e.acc  = i_v && a_v && !e.st;
        e.pend = model_pending();
        cur_acc = e.acc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ra_fwd", 32'(ra_fwd), 32'(mon_e.fa));
            check("rb_fwd", 32'(rb_fwd), 32'(mon_e.fb));
            check("stall", 32'(stall), 32'(mon_e.st));
            check("issue_accepted", 32'(issue_accepted), 32'(mon_e.acc));
            check("pending", 32'(pending), 32'(mon_e.pend));
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        drive(0, 1, 1, 3, 0, 3'b000, 1, 3, 1, 3);
        drive(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        // ALU writer forwarded then reaches the register file
        drive(1, 1, 1, 3, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 3'b000, 1, 3, 0, 0);
        drive(1, 1, 0, 0, 0, 3'b000, 1, 3, 0, 0);
        drive(1, 1, 0, 0, 0, 3'b000, 1, 3, 0, 0);
        // load-use stall then bubble
        drive(1, 1, 1, 5, 1, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 6, 0, 3'b000, 0, 0, 1, 5);
        drive(1, 1, 0, 0, 0, 3'b000, 0, 0, 1, 5);
        drive(1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        // youngest wins: ALU r2 older, load r2 younger; then ALU younger
        drive(1, 1, 1, 2, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 2, 1, 3'b000, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 3'b000, 1, 2, 1, 2);
        drive(1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        drive(1, 1, 1, 2, 1, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 2, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 3'b000, 1, 2, 0, 0);
        // selective flush of slots 0 and 1 while slot 2 retires
        drive(1, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 4, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 6, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 3'b011, 1, 4, 1, 6);
        drive(1, 1, 0, 0, 0, 3'b000, 1, 1, 1, 4);
        // adv held low with issue, then register 0 issue and read
        drive(1, 1, 1, 3, 0, 3'b000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 7, 0, 3'b000, 1, 3, 0, 0);
        drive(1, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 3'b000, 1, 0, 1, 0);
        // asynchronous reset between edges, then recovery
        drive(1, 1, 1, 1, 1, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 2, 1, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 4, 0, 3'b000, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 3'b000, 1, 2, 1, 4);
        drive(0, 1, 1, 5, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 1, 1, 7, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 3'b000, 1, 7, 0, 0);
        // randomized traffic on a narrow address range to provoke hazards
        for (int c = 0; c < 1500; c++) begin
            bit r_v;
            r_v = !((c % 500) == 499);
            drive(r_v, $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
                  AW'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 9) == 0) ? DEPTH'($urandom_range(1, 7)) : 3'b000,
                  $urandom_range(0, 4) != 0, AW'($urandom_range(0, 3)),
                  $urandom_range(0, 4) != 0, AW'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
